dir_cmd_sched: RTL and testbench

- Direction/command scheduler for the snake game.
- Merges two one-hot key sources: IR key pulses (held about 5000 cycles) and debounced board buttons (1-cycle pulses).
- Queues direction requests and releases one per game tick. Filters snake reversals and duplicates.
- Runs the game run/pause/over state and emits speed and restart control pulses to the game core.

---
 rtl/snake_pkg.sv | 41 ++++
 rtl/dir_fifo.sv | 60 ++++++
 rtl/dir_cmd_sched.sv | 154 +++++++++++++++
 tb/tb_dir_cmd_sched.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared encodings for the snake direction/command scheduler.
package snake_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam int NKEYS       = 7;
    localparam int KEY_UP      = 0;
    localparam int KEY_DOWN    = 1;
    localparam int KEY_LEFT    = 2;
    localparam int KEY_RIGHT   = 3;
    localparam int KEY_START   = 4;
    localparam int KEY_SPEED   = 5;
    localparam int KEY_RESTART = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_OVER  = 2'b11
    } state_e;

    // Opposite directions share the axis bit and differ in the sign bit.
    function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
        return (a[1] == b[1]) && (a[0] != b[0]);
    endfunction

    function automatic logic is_onehot7(input logic [NKEYS-1:0] v);
        return (v != 7'd0) && ((v & (v - 7'd1)) == 7'd0);
    endfunction

    function automatic logic [1:0] dir_enc(input logic [3:0] v);
        if (v[KEY_DOWN])       return DIR_DOWN;
        else if (v[KEY_LEFT])  return DIR_LEFT;
        else if (v[KEY_RIGHT]) return DIR_RIGHT;
        else                   return DIR_UP;
    endfunction

endpackage

// File: rtl/dir_fifo.sv
// Small synchronous FIFO with occupancy count, flush and tail peek.
module dir_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          pop_i,
    output logic [W-1:0]  rdata_o,
    output logic [W-1:0]  tail_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [DEPTH-1:0][W-1:0] mem_q;
    logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]           count_q;
    logic                    push_ok, pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign tail_o  = mem_q[wr_ptr_q - AW'(1)];

    // A full FIFO still takes a write when the same cycle frees a slot.
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/dir_cmd_sched.sv
// Snake key merger: edge-detects IR/button keys, queues directions per tick, runs game state.
module dir_cmd_sched
    import snake_pkg::*;
#(
    parameter  int         QDEPTH    = 4,
    parameter  bit         BTN_PRIO  = 1'b1,
    parameter  logic [1:0] RESET_DIR = 2'b11,
    localparam int         CW        = $clog2(QDEPTH) + 1
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    input  logic [6:0]      ir_key,
    input  logic [6:0]      btn_key,
    input  logic            game_tick,
    input  logic            game_over,
    output logic [1:0]      cur_dir,
    output logic            dir_upd,
    output logic            run,
    output logic [1:0]      state,
    output logic            speed_pls,
    output logic            restart_pls,
    output logic [CW-1:0]   q_count,
    output logic            q_ovf
);

    logic [6:0] ir_prev_q, btn_prev_q;
    logic [6:0] ir_ev, btn_ev;
    logic       ir_ok, btn_ok, ir_dir_v, btn_dir_v, use_btn, dir_v;
    logic [1:0] dir_sel;
    logic [2:0] cmd;
    logic       ev_start, ev_speed, ev_restart;

    state_e     state_q;
    logic       run_q, speed_q, restart_q;
    logic [1:0] cur_dir_q, cur_dir_d;
    logic       dir_upd_q, dir_upd_d;
    logic       q_ovf_q, q_ovf_d;

    logic       in_run, flush, pop, acc, is_new, push;
    logic [1:0] ref_dir, fifo_head, fifo_tail;
    logic       fifo_full, fifo_empty;

    // A source whose new-press vector is not one-hot contributes nothing this cycle.
    assign ir_ev     = ir_key & ~ir_prev_q;
    assign btn_ev    = btn_key & ~btn_prev_q;
    assign ir_ok     = is_onehot7(ir_ev);
    assign btn_ok    = is_onehot7(btn_ev);
    assign ir_dir_v  = ir_ok & (|ir_ev[3:0]);
    assign btn_dir_v = btn_ok & (|btn_ev[3:0]);
    assign use_btn   = btn_dir_v & (BTN_PRIO | ~ir_dir_v);
    assign dir_v     = btn_dir_v | ir_dir_v;
    assign dir_sel   = use_btn ? dir_enc(btn_ev[3:0]) : dir_enc(ir_ev[3:0]);

    assign cmd        = (ir_ok ? ir_ev[6:4] : 3'b000) | (btn_ok ? btn_ev[6:4] : 3'b000);
    assign ev_start   = cmd[KEY_START - 4];
    assign ev_speed   = cmd[KEY_SPEED - 4];
    assign ev_restart = cmd[KEY_RESTART - 4];

    assign in_run  = (state_q == ST_RUN);
    assign flush   = ev_restart | (in_run & game_over);
    assign pop     = game_tick & in_run & ~fifo_empty & ~flush;
    assign acc     = dir_v & in_run & ~flush;
    // Compare against the pre-pop tail; with one entry that is the value being popped.
    assign ref_dir = fifo_empty ? cur_dir_q : fifo_tail;
    assign is_new  = (dir_sel != ref_dir);
    assign push    = acc & is_new & (~fifo_full | pop);
    assign q_ovf_d = acc & is_new & fifo_full & ~pop;

    always_comb begin
        cur_dir_d = cur_dir_q;
        dir_upd_d = 1'b0;
        if (ev_restart) begin
            cur_dir_d = RESET_DIR;
        end else if (pop && !is_reverse(fifo_head, cur_dir_q)) begin
            cur_dir_d = fifo_head;
            dir_upd_d = 1'b1;
        end
    end

    dir_fifo #(.DEPTH(QDEPTH), .W(2)) u_fifo (
        .clk_i   (sys_clk),
        .rst_ni  (sys_rst_n),
        .flush_i (flush),
        .push_i  (push),
        .wdata_i (dir_sel),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .tail_o  (fifo_tail),
        .count_o (q_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ir_prev_q  <= '0;
            btn_prev_q <= '0;
            cur_dir_q  <= RESET_DIR;
            dir_upd_q  <= 1'b0;
            q_ovf_q    <= 1'b0;
        end else begin
            ir_prev_q  <= ir_key;
            btn_prev_q <= btn_key;
            cur_dir_q  <= cur_dir_d;
            dir_upd_q  <= dir_upd_d;
            q_ovf_q    <= q_ovf_d;
        end
    end

    // Restart overrides everything; game_over beats START while running.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= ST_IDLE;
            run_q     <= 1'b0;
            speed_q   <= 1'b0;
            restart_q <= 1'b0;
        end else begin
            restart_q <= ev_restart;
            speed_q   <= ev_speed & ~ev_restart & (state_q == ST_RUN || state_q == ST_PAUSE);
            if (ev_restart) begin
                state_q <= ST_IDLE;
                run_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: if (ev_start) begin
                        state_q <= ST_RUN;
                        run_q   <= 1'b1;
                    end
                    ST_RUN: if (game_over) begin
                        state_q <= ST_OVER;
                        run_q   <= 1'b0;
                    end else if (ev_start) begin
                        state_q <= ST_PAUSE;
                        run_q   <= 1'b0;
                    end
                    ST_PAUSE: if (ev_start) begin
                        state_q <= ST_RUN;
                        run_q   <= 1'b1;
                    end
                    default: state_q <= ST_OVER;
                endcase
            end
        end
    end

    assign cur_dir     = cur_dir_q;
    assign dir_upd     = dir_upd_q;
    assign run         = run_q;
    assign state       = state_q;
    assign speed_pls   = speed_q;
    assign restart_pls = restart_q;
    assign q_ovf       = q_ovf_q;

endmodule

// File: tb/tb_dir_cmd_sched.sv
// Directed bench for dir_cmd_sched with a direction scoreboard; a second instance covers IR priority.
module tb_dir_cmd_sched;
    import snake_pkg::*;

    localparam logic [6:0] K_UP = 7'b0000001, K_DN = 7'b0000010, K_LF = 7'b0000100,
                           K_RT = 7'b0001000, K_ST = 7'b0010000, K_SP = 7'b0100000,
                           K_RS = 7'b1000000;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic [6:0] ir_key = '0, btn_key = '0;
    logic       game_tick = 1'b0, game_over = 1'b0;

    logic [1:0] a_cur, a_state, b_cur, b_state;
    logic       a_upd, a_run, a_spd, a_rst, a_ovf, b_upd, b_run, b_spd, b_rst, b_ovf;
    logic [2:0] a_cnt, b_cnt;

    int npass = 0, ntot = 0, nfail = 0;
    logic [1:0] mq[$];
    logic [1:0] mcur;

    always #5 clk = ~clk;

    dir_cmd_sched #(.QDEPTH(4), .BTN_PRIO(1'b1), .RESET_DIR(2'b11)) u_dut1 (
        .sys_clk(clk), .sys_rst_n(rst_n), .ir_key(ir_key), .btn_key(btn_key),
        .game_tick(game_tick), .game_over(game_over), .cur_dir(a_cur), .dir_upd(a_upd),
        .run(a_run), .state(a_state), .speed_pls(a_spd), .restart_pls(a_rst),
        .q_count(a_cnt), .q_ovf(a_ovf));

    dir_cmd_sched #(.QDEPTH(4), .BTN_PRIO(1'b0), .RESET_DIR(2'b11)) u_dut0 (
        .sys_clk(clk), .sys_rst_n(rst_n), .ir_key(ir_key), .btn_key(btn_key),
        .game_tick(game_tick), .game_over(game_over), .cur_dir(b_cur), .dir_upd(b_upd),
        .run(b_run), .state(b_state), .speed_pls(b_spd), .restart_pls(b_rst),
        .q_count(b_cnt), .q_ovf(b_ovf));

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        ntot++;
        assert (got === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic btn(input logic [6:0] k);
        btn_key = k;
        @(negedge clk);
        btn_key = '0;
    endtask

    // Pops the model queue on a tick and checks the direction outcome.
    task automatic sb_tick(input string tag);
        logic [1:0] h;
        game_tick = 1'b1;
        @(negedge clk);
        game_tick = 1'b0;
        if (mq.size() > 0) begin
            h = mq.pop_front();
            if ((h[1] == mcur[1]) && (h[0] != mcur[0])) begin
                chk({tag, "_cur"}, 8'(a_cur), 8'(mcur));
                chk({tag, "_upd"}, 8'(a_upd), 8'd0);
            end else begin
                mcur = h;
                chk({tag, "_cur"}, 8'(a_cur), 8'(h));
                chk({tag, "_upd"}, 8'(a_upd), 8'd1);
            end
        end
        chk({tag, "_cnt"}, 8'(a_cnt), 8'(mq.size()));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        cyc(2);
        chk("rst_state", 8'(a_state), 8'd0);
        chk("rst_cur", 8'(a_cur), 8'd3);
        chk("rst_cnt", 8'(a_cnt), 8'd0);
        chk("rst_pulses", {4'd0, a_upd, a_spd, a_rst, a_ovf}, 8'd0);
        chk("rst_run", 8'(a_run), 8'd0);
        rst_n = 1'b1;
        cyc(1);
        mcur = 2'b11;

        btn(K_ST);
        chk("start_state", 8'(a_state), 8'd1);
        chk("start_run", 8'(a_run), 8'd1);
        chk("start_cur", 8'(a_cur), 8'd3);
        chk("start_cnt", 8'(a_cnt), 8'd0);
        chk("start_state0", 8'(b_state), 8'd1);

        // IR held ~5000 cycles gives a single event
        ir_key = K_UP;
        @(negedge clk);
        mq.push_back(DIR_UP);
        chk("ir_cnt1", 8'(a_cnt), 8'd1);
        cyc(4998);
        chk("ir_hold_cnt", 8'(a_cnt), 8'd1);
        sb_tick("ir_up");
        ir_key = '0;
        cyc(1);
        chk("ir_upd_off", 8'(a_upd), 8'd0);
        chk("ir_cnt_after", 8'(a_cnt), 8'd0);

        btn(K_RT);
        mq.push_back(DIR_RIGHT);
        chk("rt_cnt", 8'(a_cnt), 8'd1);
        sb_tick("rt");

        btn(K_LF);
        mq.push_back(DIR_LEFT);
        chk("lf_cnt", 8'(a_cnt), 8'd1);
        sb_tick("rev");

        btn(K_UP | K_DN);
        chk("multihot_cnt", 8'(a_cnt), 8'd0);
        cyc(1);

        btn_key = K_UP;
        ir_key  = K_DN;
        @(negedge clk);
        btn_key = '0;
        ir_key  = '0;
        chk("coll_cnt1", 8'(a_cnt), 8'd1);
        chk("coll_cnt0", 8'(b_cnt), 8'd1);
        mq.push_back(DIR_UP);
        sb_tick("coll_btn");
        chk("coll_ir_cur", 8'(b_cur), 8'd1);
        chk("coll_ir_upd", 8'(b_upd), 8'd1);

        btn(K_RT);
        mq.push_back(DIR_RIGHT);
        sb_tick("resync");
        chk("resync_cur0", 8'(b_cur), 8'd3);

        btn(K_UP); mq.push_back(DIR_UP);
        btn(K_LF); mq.push_back(DIR_LEFT);
        btn(K_DN); mq.push_back(DIR_DOWN);
        btn(K_RT); mq.push_back(DIR_RIGHT);
        chk("fill_cnt", 8'(a_cnt), 8'd4);
        btn(K_UP);
        chk("ovf_pulse", 8'(a_ovf), 8'd1);
        chk("ovf_cnt", 8'(a_cnt), 8'd4);
        cyc(1);
        chk("ovf_clear", 8'(a_ovf), 8'd0);

        // push into a full FIFO together with a pop
        btn_key   = K_UP;
        game_tick = 1'b1;
        @(negedge clk);
        btn_key   = '0;
        game_tick = 1'b0;
        void'(mq.pop_front());
        mcur = DIR_UP;
        mq.push_back(DIR_UP);
        chk("pp_cnt", 8'(a_cnt), 8'd4);
        chk("pp_cur", 8'(a_cur), 8'd0);
        chk("pp_upd", 8'(a_upd), 8'd1);
        chk("pp_ovf", 8'(a_ovf), 8'd0);

        btn(K_ST);
        chk("pause_state", 8'(a_state), 8'd2);
        chk("pause_run", 8'(a_run), 8'd0);
        btn(K_SP);
        chk("pause_speed", 8'(a_spd), 8'd1);
        btn(K_RT);
        chk("pause_dir_ign", 8'(a_cnt), 8'd4);
        game_tick = 1'b1;
        @(negedge clk);
        game_tick = 1'b0;
        chk("pause_tick_cur", 8'(a_cur), 8'd0);
        chk("pause_tick_cnt", 8'(a_cnt), 8'd4);
        btn(K_ST);
        chk("resume_state", 8'(a_state), 8'd1);
        btn(K_SP);
        chk("run_speed", 8'(a_spd), 8'd1);
        cyc(1);
        chk("speed_off", 8'(a_spd), 8'd0);

        sb_tick("pop_lf");
        sb_tick("pop_dn");

        game_over = 1'b1;
        @(negedge clk);
        game_over = 1'b0;
        mq.delete();
        chk("over_state", 8'(a_state), 8'd3);
        chk("over_cnt", 8'(a_cnt), 8'd0);
        chk("over_run", 8'(a_run), 8'd0);
        btn(K_ST);
        chk("over_start_ign", 8'(a_state), 8'd3);
        btn(K_UP);
        chk("over_dir_ign", 8'(a_cnt), 8'd0);
        btn(K_SP);
        chk("over_speed_ign", 8'(a_spd), 8'd0);

        btn(K_RS);
        chk("rs_state", 8'(a_state), 8'd0);
        chk("rs_cur", 8'(a_cur), 8'd3);
        chk("rs_pls", 8'(a_rst), 8'd1);
        cyc(1);
        chk("rs_pls_off", 8'(a_rst), 8'd0);

        btn(K_SP);
        chk("idle_speed_ign", 8'(a_spd), 8'd0);
        btn(K_UP);
        chk("idle_dir_ign", 8'(a_cnt), 8'd0);

        btn(K_ST);
        chk("rerun_state", 8'(a_state), 8'd1);
        cyc(1);
        btn_key   = K_ST;
        game_over = 1'b1;
        @(negedge clk);
        btn_key   = '0;
        game_over = 1'b0;
        chk("go_beats_start", 8'(a_state), 8'd3);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
